// File: rtl/pci_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : pci_arb_rr
// Description : Round-robin PCI bus arbiter for N masters. Samples active-low
//               REQ# lines, drives at most one registered active-low GNT#,
//               hands the bus over following FRAME#/IRDY# activity and
//               reclaims an unused grant after TMO idle cycles.
//               Optional bus parking is enabled by defining PCI_ARB_PARK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pci_arb_rr #(
    parameter int N    = 4,
    parameter int TMO  = 16,
    parameter int PARK = 0,
    localparam int IW  = $clog2(N),
    localparam int TW  = $clog2(TMO + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_n,
    input  logic          frame_n,
    input  logic          irdy_n,
    output logic [N-1:0]  gnt_n,
    output logic [IW-1:0] owner,
    output logic          owner_vld,
    output logic          tmo_pulse
);

`ifdef PCI_ARB_PARK_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_BUSY   = 3'd2,
        S_DRAIN  = 3'd3,
        S_PARKED = 3'd4
    } state_t;

    localparam logic [IW-1:0] c_park      = IW'(PARK);
    localparam logic [IW-1:0] c_park_next = (PARK == N - 1) ? '0 : IW'(PARK + 1);
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_BUSY   = 3'd2,
        S_DRAIN  = 3'd3
    } state_t;
`endif

    localparam logic [TW-1:0] c_tmo_last = TW'(TMO - 1);
    localparam logic [IW:0]   c_n        = (IW + 1)'(N);
    localparam logic [IW-1:0] c_last_idx = IW'(N - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  req_q;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [N-1:0]  gnt_n_q, gnt_n_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          owner_vld_q, owner_vld_d;
    logic          tmo_pulse_q, tmo_pulse_d;

    logic          w_idle;
    logic          w_any_req;
    logic          w_other_req;
    logic [N-1:0]  w_owner_oh;
    logic          w_win_vld;
    logic [IW-1:0] w_win_idx;
    logic [IW-1:0] w_ptr_next;
    logic [IW:0]   w_pos;

    assign w_idle    = frame_n & irdy_n;
    assign w_any_req = ~&req_q;

    // Requests from masters other than the current owner force a hand-over.
    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[owner_q] = 1'b1;
        w_other_req         = |(~req_q & ~w_owner_oh);
    end

    // Round-robin search starting at ptr; first requesting index wins.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        w_pos     = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, ptr_q} + (IW + 1)'(k);
            if (w_pos >= c_n) begin
                w_pos = w_pos - c_n;
            end
            if (!w_win_vld && !req_q[w_pos[IW-1:0]]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_pos[IW-1:0];
            end
        end
        w_ptr_next = (w_win_idx == c_last_idx) ? '0 : w_win_idx + IW'(1);
    end

    // Next-state and output decode; every hand-over passes through IDLE.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        tmr_d       = tmr_q;
        gnt_n_d     = gnt_n_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        tmo_pulse_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_win_vld) begin
                    state_d            = S_GRANT;
                    gnt_n_d            = '1;
                    gnt_n_d[w_win_idx] = 1'b0;
                    owner_d            = w_win_idx;
                    owner_vld_d        = 1'b1;
                    ptr_d              = w_ptr_next;
                    tmr_d              = '0;
                end
`ifdef PCI_ARB_PARK_EN
                else begin
                    state_d         = S_PARKED;
                    gnt_n_d         = '1;
                    gnt_n_d[c_park] = 1'b0;
                    owner_d         = c_park;
                    owner_vld_d     = 1'b1;
                end
`endif
            end
            S_GRANT: begin
                if (!frame_n) begin
                    state_d = S_BUSY;
                    tmr_d   = '0;
                end else if (req_q[owner_q] && w_idle) begin
                    state_d     = S_IDLE;
                    gnt_n_d     = '1;
                    owner_vld_d = 1'b0;
                    tmr_d       = '0;
                end else if (w_idle) begin
                    if (tmr_q == c_tmo_last) begin
                        // Unused grant reclaimed; ptr already points past owner.
                        state_d     = S_IDLE;
                        gnt_n_d     = '1;
                        owner_vld_d = 1'b0;
                        tmr_d       = '0;
                        tmo_pulse_d = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
            end
            S_BUSY: begin
                if (w_other_req) begin
                    // Withdraw GNT# early; the owner finishes its current burst.
                    state_d     = S_DRAIN;
                    gnt_n_d     = '1;
                    owner_vld_d = 1'b0;
                end else if (w_idle) begin
                    if (!req_q[owner_q]) begin
                        state_d = S_GRANT;
                        tmr_d   = '0;
                    end else begin
                        state_d     = S_IDLE;
                        gnt_n_d     = '1;
                        owner_vld_d = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                if (w_idle) begin
                    state_d = S_IDLE;
                end
            end
`ifdef PCI_ARB_PARK_EN
            S_PARKED: begin
                if (!frame_n) begin
                    state_d = S_BUSY;
                end else if (!req_q[c_park]) begin
                    state_d = S_GRANT;
                    ptr_d   = c_park_next;
                    tmr_d   = '0;
                end else if (w_any_req && w_idle) begin
                    state_d     = S_IDLE;
                    gnt_n_d     = '1;
                    owner_vld_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d     = S_IDLE;
                gnt_n_d     = '1;
                owner_vld_d = 1'b0;
                tmr_d       = '0;
            end
        endcase
    end

    // State, request sampling and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_q       <= '1;
            ptr_q       <= '0;
            tmr_q       <= '0;
            gnt_n_q     <= '1;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            tmo_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_n;
            ptr_q       <= ptr_d;
            tmr_q       <= tmr_d;
            gnt_n_q     <= gnt_n_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            tmo_pulse_q <= tmo_pulse_d;
        end
    end

    assign gnt_n     = gnt_n_q;
    assign owner     = owner_q;
    assign owner_vld = owner_vld_q;
    assign tmo_pulse = tmo_pulse_q;

endmodule
`default_nettype wire

// File: doc/pci_arb_rr.md
# pci_arb_rr

Parametrised PCI bus arbiter for N bus masters on the local PCI segment. It samples the active-low per-master REQ# lines and issues at most one active-low GNT#. Grants are round-robin, so no master can be starved. Grant hand-over follows bus activity on FRAME#/IRDY#, and an unused grant is reclaimed after a timeout. It replaces the fixed-priority four-master arbiter and sits beside the central PCI resource logic, driving the GNT# pins directly.

## Interface
- `N`, default 4: number of masters, valid range 2..16.
- `TMO`, default 16: idle-bus cycles a granted master may hold GNT# without asserting FRAME#, valid range 1..255.
- `PARK`, default 0: index of the park master, used only with `PCI_ARB_PARK_EN`.
- `IW` (derived): clog2(N). `TW` (derived): clog2(TMO+1).
- `clk` input, 1 bit: PCI clock; all logic on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `req_n` input, N bits: active-low request, bit i = master i.
- `frame_n` input, 1 bit: PCI FRAME#, active low.
- `irdy_n` input, 1 bit: PCI IRDY#, active low.
- `gnt_n` output, N bits: active-low grant, registered; at most one bit low.
- `owner` output, IW bits: index of the current or last grantee, registered.
- `owner_vld` output, 1 bit: high while any `gnt_n` bit is low.
- `tmo_pulse` output, 1 bit: one-cycle pulse when a grant is reclaimed by timeout.

## Operation
- Bus idle: `idle = frame_n & irdy_n`.
- Arbitration pointer `ptr` (IW bits). Search order is ptr, ptr+1, … modulo N.
  - Winner = first index with `req_n` low.
  - After issuing a grant to w: `ptr <= (w+1) mod N`, wrapping from N-1 to 0.
- IDLE: all `gnt_n` high.
  - Any request present: go to GRANT with the winner; `gnt_n[w]` goes low at that edge.
  - Otherwise: go to PARKED when `PCI_ARB_PARK_EN` is defined, else stay in IDLE.
- GRANT: `gnt_n[owner]` low; the timer counts edges where `idle` holds.
  - `frame_n` low: go to BUSY and clear the timer.
  - `req_n[owner]` high and `idle`: go to IDLE.
  - Timer reaches TMO: go to IDLE and pulse `tmo_pulse`. `ptr` already points past the owner.
- BUSY: the owner's transaction is in progress.
  - Another master requesting (any `req_n[j]` low, j≠owner): release `gnt_n[owner]` and go to DRAIN.
  - Otherwise hold the grant. When `idle` returns: go to GRANT if `req_n[owner]` is low, else go to IDLE.
- DRAIN: all `gnt_n` high; wait for `idle`, then go to IDLE.
- Every hand-over passes through IDLE with all `gnt_n` high for at least one cycle. Two grants are never driven low on the same cycle.
- Simultaneous requests: the lowest distance from `ptr` wins. At reset `ptr = 0`, so index 0 wins first.
- `owner` keeps its last value when `owner_vld` is low.
- A request withdrawn before it is sampled is ignored; no grant is issued for it.
- Reset mid-transaction: outputs return to reset values immediately (asynchronous). After release, the FSM restarts in IDLE with no regard to `frame_n`.

## Timing
- Reset values:
  - `gnt_n` all ones, `owner` 0, `owner_vld` 0, `tmo_pulse` 0.
  - `ptr` 0, timer 0, state IDLE.
- Grant latency: a request first sampled low at edge k in IDLE drives `gnt_n` low after edge k+1. This is one state hop; no combinational path exists from `req_n` to `gnt_n`.
- Timeout: the grant is removed on the edge where the idle count reaches TMO.
  - With `frame_n` held high, `gnt_n` stays low for exactly TMO cycles.
- BUSY→DRAIN: `gnt_n` goes high on the edge after the competing request is sampled. FRAME# may still be low at that point, as PCI permits.
- `owner_vld` and `gnt_n` change on the same edge.

## Configuration
- `PCI_ARB_PARK_EN` defined: the PARKED state exists.
  - PARKED drives `gnt_n[PARK]` low, `owner = PARK`, `owner_vld = 1`.
  - `req_n[PARK]` low: go directly to GRANT with owner PARK, without a dead cycle.
  - Any other request and `idle`: go to IDLE, then arbitrate.
  - `frame_n` low while PARKED: go to BUSY with owner PARK.
- `PCI_ARB_PARK_EN` undefined: no PARKED state; with no requests, all `gnt_n` stay high. `PARK` is ignored.

## Test plan
- Reset and single request:
  - Stimulus: assert `rst`; release it with `req_n=4'b1111`, then drive `req_n=4'b1011`.
  - Required: all `gnt_n` high after reset; `gnt_n=4'b1011` and `owner=2` two edges after the request.
- Round-robin fairness:
  - Stimulus: all four requests held low; each grantee runs a 3-cycle FRAME#.
  - Required: grant order 0,1,2,3,0, each separated by at least one all-high cycle.
- Timeout:
  - Stimulus: master 1 granted, `frame_n` held high, TMO=16.
  - Required: `gnt_n[1]` low for exactly 16 cycles; `tmo_pulse` high for 1 cycle; the next grant goes to index 2 if requesting.
- Pre-emption:
  - Stimulus: master 0 in BUSY, master 3 asserts `req_n`.
  - Required: `gnt_n[0]` high the next edge; `gnt_n[3]` low only after `frame_n`/`irdy_n` both return high, plus one IDLE cycle.
- Parking with `PCI_ARB_PARK_EN`, PARK=0, no requests:
  - Required: `gnt_n=4'b1110` and `owner_vld=1`.
  - Then `req_n=4'b1101`: one all-high cycle, then `gnt_n=4'b1101`.
- Reset mid-BUSY:
  - Stimulus: assert `rst` asynchronously between edges.
  - Required: `gnt_n` returns to all ones without waiting for a clock edge; the first grant after release goes to index 0 if it is requesting.
